// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares the single port of a 4096-word RAM (synchronous write,
//   combinational read) between two requesters using round-robin priority.
//   After reset it can sweep CLEAR_VAL into every word before it grants
//   any access.
//
// Ports
//   clk, rst_n                  clock (rising edge), synchronous active-low reset
//   rN_req/we/addr/wdata        requester N access request (N = 0 CPU, 1 loader)
//   rN_gnt                      request accepted this cycle
//   rN_rvalid/rdata             read data, one-cycle pulse; rdata held until the next read
//   mem_addr/mem_in/mem_load    RAM address, write data, write enable
//   mem_out                     RAM read data (combinational from mem_addr)
//   clear_done                  high once the sweep has completed
module ram_port_arbiter #(
  parameter int                 DATA_W    = 16,
  parameter int                 ADDR_W    = 12,
  parameter bit                 CLEAR_EN  = 1'b1,
  parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,

  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out,

  output logic              clear_done
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic              prio;      // requester that wins a tie
  logic              last_clr;

  assign last_clr = (clr_cnt == {ADDR_W{1'b1}});

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked assignment uses <= so all registers update together
  // from values sampled before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if (CLEAR_EN) state <= ST_CLEAR;
      else          state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: the sweep ends after the last address; RUN is left
  // only through reset.
  // ---------------------------------------------------------------------------
  // NOTE: assigning a default before any branch keeps this block purely
  // combinational; a path that skips the assignment would infer a latch.
  always_comb begin
    state_nxt = state;
    if (state == ST_CLEAR && last_clr) state_nxt = ST_RUN;
  end

  // ---------------------------------------------------------------------------
  // Output logic: grant selection and RAM drive
  // ---------------------------------------------------------------------------
  always_comb begin
    r0_gnt   = 1'b0;
    r1_gnt   = 1'b0;
    mem_addr = '0;
    mem_in   = '0;
    mem_load = 1'b0;
    if (state == ST_CLEAR) begin
      // The sweep keeps driving the RAM even while reset is asserted; those
      // words are rewritten once the restarted sweep reaches them.
      mem_addr = clr_cnt;
      mem_in   = CLEAR_VAL;
      mem_load = 1'b1;
    end else if (rst_n) begin
      // Grants are suppressed during reset so a write can never be committed
      // on an edge that also resets the controller.
      r0_gnt = r0_req & (~r1_req | ~prio);
      r1_gnt = r1_req & (~r0_req |  prio);
      if (r0_gnt) begin
        mem_addr = r0_addr;
        mem_in   = r0_we ? r0_wdata : '0;
        mem_load = r0_we;
      end else if (r1_gnt) begin
        mem_addr = r1_addr;
        mem_in   = r1_we ? r1_wdata : '0;
        mem_load = r1_we;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sweep counter, priority and read-return registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_cnt    <= '0;
      prio       <= 1'b0;
      clear_done <= ~CLEAR_EN;
      r0_rvalid  <= 1'b0;
      r1_rvalid  <= 1'b0;
      r0_rdata   <= '0;
      r1_rdata   <= '0;
    end else begin
      if (state == ST_CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (last_clr) clear_done <= 1'b1;
      end

      // Round robin: the requester just served drops to lower priority.
      if (r0_gnt)      prio <= 1'b1;
      else if (r1_gnt) prio <= 1'b0;

      // Read data is captured from the combinational RAM output during the
      // grant cycle and presented, with its valid pulse, in the next cycle.
      r0_rvalid <= r0_gnt & ~r0_we;
      r1_rvalid <= r1_gnt & ~r1_we;
      if (r0_gnt && !r0_we) r0_rdata <= mem_out;
      if (r1_gnt && !r1_we) r1_rdata <= mem_out;
    end
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester controller in front of the 4096-word RAM cluster (ram4096, 16-bit words, 12-bit address).
- Shares the single RAM port between requester 0 (CPU data path) and requester 1 (loader/DMA) using round-robin arbitration.
- After reset, sequences a full clear of the RAM before granting any access.
- RAM contract: write is synchronous, committed on the clk edge when mem_load=1. Read is combinational (mem_out = word at mem_addr).

Parameters:
- DATA_W, 16, word width
- ADDR_W, 12, address width; DEPTH = 2**ADDR_W
- CLEAR_EN, 1, 1 = run the zero-fill sweep after reset; 0 = enter RUN directly
- CLEAR_VAL, 16'h0000, value written to every word during the sweep

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- r0_req  in  1  requester 0 access request
- r0_we  in  1  1 = write, 0 = read
- r0_addr  in  ADDR_W  word address
- r0_wdata  in  DATA_W  write data
- r0_gnt  out  1  request accepted this cycle
- r0_rvalid  out  1  read data valid, 1-cycle pulse
- r0_rdata  out  DATA_W  read data, held until the next r0 read
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata: same as r0, for requester 1
- mem_addr  out  ADDR_W  RAM address
- mem_in  out  DATA_W  RAM write data
- mem_load  out  1  RAM write enable
- mem_out  in  DATA_W  RAM read data (combinational)
- clear_done  out  1  high once the sweep completes, stays high until reset

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-low, named rst_n, sampled on the rising edge of clk.
- Reset values:
  - state = CLEAR if CLEAR_EN, else RUN
  - clr_cnt = 0, prio = 0
  - r0_rvalid = r1_rvalid = 0, r0_rdata = r1_rdata = 0
  - clear_done = !CLEAR_EN
- State CLEAR:
  - mem_addr = clr_cnt, mem_in = CLEAR_VAL, mem_load = 1.
  - clr_cnt increments each cycle.
  - When clr_cnt == DEPTH-1, the next state is RUN and clear_done is set to 1 on the same edge.
  - The sweep takes exactly DEPTH cycles.
  - r0_gnt = r1_gnt = 0 throughout, even if requests are asserted.
- State RUN, grant logic (combinational, at most one grant per cycle):
  - r0_gnt = r0_req & (!r1_req | prio==0)
  - r1_gnt = r1_req & (!r0_req | prio==1)
- Priority update: on any grant, prio <= index of the other requester. With no grant, prio holds.
- Fairness bound: a continuously requesting port is granted within 2 cycles.
- Requester rule: req, we, addr and wdata must stay stable until the cycle gnt=1. Dropping req before grant withdraws the request with no side effects.
- Memory drive:
  - Granted write: mem_addr = addr, mem_in = wdata, mem_load = 1. Committed at the end of the grant cycle.
  - Granted read: mem_addr = addr, mem_load = 0. mem_out is registered into rN_rdata, and rN_rvalid = 1 in the following cycle only.
  - No grant: mem_addr = 0, mem_in = 0, mem_load = 0.
- Read latency is 1 cycle after grant. Back-to-back reads by one port give back-to-back rvalid pulses.
- Read-after-write: a write granted in cycle N followed by a read of the same address granted in cycle N+1 returns the new data.
- Simultaneous requests (either mix of read and write): serialized by prio, never merged.
- Reset mid-sweep or mid-access: all state returns to reset values on that edge. Any pending rvalid is dropped. The sweep restarts from address 0. A write is committed only if its grant cycle's edge had rst_n=1.
- No other states exist. RUN is left only by reset.

Test Plan:
- Clear sweep (CLEAR_EN=1, CLEAR_VAL=16'hA5A5): release reset and hold r0_req=1 throughout.
  - Required: mem_load=1 for exactly 4096 cycles with addresses 0..4095.
  - Required: clear_done rises on cycle 4096, and the first r0_gnt comes in the same cycle.
  - Required: a subsequent read of address 12'h7FF returns 16'hA5A5.
- Write then read on r0: write 16'h1234 to 12'h00F, then read 12'h00F next cycle.
  - Required: r0_rvalid pulses once, 1 cycle after the read grant, with r0_rdata = 16'h1234.
- Contention: r0 and r1 both hold read requests continuously, prio=0.
  - Required: grants alternate r0, r1, r0, r1.
  - Required: each rvalid follows its own grant by 1 cycle.
  - Required: no cycle has both grants high.
- Write/read race: r1 writes 16'hBEEF to 12'h100 while r0 reads 12'h100 in the same cycle, prio=1.
  - Required: r1 is granted first, r0 is granted next cycle, and r0 reads 16'hBEEF.
- Reset mid-sweep: assert rst_n=0 at clr_cnt=2000.
  - Required: mem_load=1 throughout the reset cycle, with mem_addr=2000 (the sweep keeps driving the RAM).
  - Required: after release the sweep restarts at address 0 and runs the full 4096 cycles.
  - Required: clear_done stays low until the sweep finishes.
- Withdrawn request (CLEAR_EN=0): r0 holds req=1 while r1 is being granted, then drops req before its own grant.
  - Required: no r0 grant, no memory write, and prio unchanged from r1's last update.
